// File: rtl/mem_multichannel_packetizer_pkg.sv
// Shared flit encoding constants, TX FSM states and width helpers for the
// multichannel memory packetizer and its arbiter.
package mem_multichannel_packetizer_pkg;

   localparam logic [1:0] TYPE_SINGLE = 2'b11;
   localparam logic [1:0] TYPE_HEAD   = 2'b10;
   localparam logic [1:0] TYPE_BODY   = 2'b00;
   localparam logic [1:0] TYPE_TAIL   = 2'b01;

   localparam logic [2:0] MSG_READ    = 3'b001;
   localparam logic [2:0] MSG_WRITE   = 3'b010;
   localparam logic [2:0] MSG_RD_RESP = 3'b100;
   localparam logic [2:0] MSG_WR_ACK  = 3'b101;

   typedef enum logic {StIdle, StHeadSent} tx_state_e;

   // Index width for n items; never returns 0 so one-item vectors stay legal.
   function automatic int unsigned log2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return (r == 0) ? 1 : r;
   endfunction

   function automatic int unsigned flow_bits(input int unsigned id_bits,
                                             input int unsigned extra);
      return 2 * id_bits + extra;
   endfunction

   function automatic int unsigned flit_width(input int unsigned flow, input int unsigned typ,
                                              input int unsigned vc, input int unsigned data);
      return flow + typ + vc + data;
   endfunction

endpackage

// File: rtl/mem_multichannel_packetizer_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the registered
// pointer; the pointer moves past the winner whenever the grant is taken.
module mem_multichannel_packetizer_rr_arbiter
   import mem_multichannel_packetizer_pkg::*;
#(
   parameter int unsigned N = 2,
   localparam int unsigned IDX_W = log2(N)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   logic [IDX_W-1:0] ptr_q;

   always_comb begin
      int unsigned idx;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = (int'(ptr_q) + i) % N;
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant[idx]  = 1'b1;
            grant_idx   = IDX_W'(idx);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         ptr_q <= '0;
      end else if (advance && grant_valid) begin
         ptr_q <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/mem_multichannel_packetizer.sv
// Multichannel memory packetizer: per-channel request buffers feed a round-robin
// TX FSM into the router; responses are steered back by the flow extra field.
module mem_multichannel_packetizer
   import mem_multichannel_packetizer_pkg::*;
#(
   parameter int unsigned CHANNELS     = 2,
   parameter int unsigned ID_BITS      = 4,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDRESS_BITS = 20,
   parameter int unsigned VC_BITS      = 1,
   parameter int unsigned EXTRA        = 2,
   parameter int unsigned TYPE_BITS    = 2,
   parameter int unsigned MSG_BITS     = 3,
   parameter int unsigned OUT_BITS     = 2,
   parameter int unsigned STAT_WIDTH   = 32,
   localparam int unsigned FLOW_BITS   = flow_bits(ID_BITS, EXTRA),
   localparam int unsigned FLIT_WIDTH  = flit_width(FLOW_BITS, TYPE_BITS, VC_BITS, DATA_WIDTH)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [ID_BITS-1:0]               core_ID,
   input  logic [CHANNELS-1:0]              ch_read,
   input  logic [CHANNELS-1:0]              ch_write,
   input  logic [CHANNELS*ADDRESS_BITS-1:0] ch_address,
   input  logic [CHANNELS*DATA_WIDTH-1:0]   ch_in_data,
   output logic [CHANNELS-1:0]              ch_ready,
   output logic [CHANNELS-1:0]              ch_valid,
   output logic [CHANNELS*DATA_WIDTH-1:0]   ch_out_data,
   output logic [FLIT_WIDTH-1:0]            flit_out,
   output logic                             valid_out,
   input  logic [2**VC_BITS-1:0]            router_full,
   input  logic [FLIT_WIDTH-1:0]            flit_in,
   input  logic                             valid_in,
   output logic                             err,
   output logic [STAT_WIDTH-1:0]            stat_sent,
   output logic [STAT_WIDTH-1:0]            stat_recv,
   output logic [STAT_WIDTH-1:0]            stat_stall
);

   localparam int unsigned CH_W = log2(CHANNELS);
   localparam logic [OUT_BITS-1:0] MAX_OUT = '1;

   logic [CHANNELS-1:0]     buf_valid, buf_write;
   logic [ADDRESS_BITS-1:0] buf_addr [CHANNELS];
   logic [DATA_WIDTH-1:0]   buf_data [CHANNELS];
   logic [OUT_BITS-1:0]     out_cnt  [CHANNELS];

   tx_state_e       state_q, state_d;
   logic [CH_W-1:0] cur_q, cur_d;

   logic [CHANNELS-1:0]   eligible, grant, capture, issue, dec;
   logic [CH_W-1:0]       grant_idx;
   logic                  grant_valid, emit, stall, rx_hit;
   logic [FLIT_WIDTH-1:0] flit_d;
   logic [TYPE_BITS-1:0]  rx_type;
   logic [MSG_BITS-1:0]   rx_msg;
   logic [EXTRA-1:0]      rx_extra;
   logic                  unused_rx;

   function automatic logic [VC_BITS-1:0] vc_of(input logic [CH_W-1:0] ch);
      return VC_BITS'(int'(ch) % (1 << VC_BITS));
   endfunction

   function automatic logic [DATA_WIDTH-1:0] head_data(input logic [2:0] msg,
                                                      input logic [ADDRESS_BITS-1:0] addr);
      logic [DATA_WIDTH-1:0] d;
      d = '0;
      d[ADDRESS_BITS-1:0] = addr;
      d[DATA_WIDTH-1 -: MSG_BITS] = MSG_BITS'(msg);
      return d;
   endfunction

   function automatic logic [FLIT_WIDTH-1:0] make_flit(input logic [CH_W-1:0] ch,
                                                      input logic [1:0] typ,
                                                      input logic [ADDRESS_BITS-1:0] addr,
                                                      input logic [DATA_WIDTH-1:0] data);
      return {core_ID, addr[ADDRESS_BITS-1 -: ID_BITS], EXTRA'(ch), TYPE_BITS'(typ),
              vc_of(ch), data};
   endfunction

   always_comb begin
      eligible = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         ch_ready[c] = !buf_valid[c] && (out_cnt[c] != MAX_OUT);
         capture[c]  = (ch_read[c] || ch_write[c]) && ch_ready[c];
         eligible[c] = buf_valid[c] && !router_full[vc_of(CH_W'(c))] && (state_q == StIdle);
      end
   end

   mem_multichannel_packetizer_rr_arbiter #(
      .N (CHANNELS)
   ) u_arb (
      .clock       (clock),
      .reset       (reset),
      .req         (eligible),
      .advance     (grant_valid),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      emit    = 1'b0;
      stall   = 1'b0;
      flit_d  = '0;
      issue   = '0;
      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               emit = 1'b1;
               if (buf_write[grant_idx]) begin
                  flit_d  = make_flit(grant_idx, TYPE_HEAD, buf_addr[grant_idx],
                                      head_data(MSG_WRITE, buf_addr[grant_idx]));
                  state_d = StHeadSent;
                  cur_d   = grant_idx;
               end else begin
                  flit_d = make_flit(grant_idx, TYPE_SINGLE, buf_addr[grant_idx],
                                     head_data(MSG_READ, buf_addr[grant_idx]));
                  issue[grant_idx] = 1'b1;
               end
            end else if (|buf_valid) begin
               stall = 1'b1;
            end
         end
         StHeadSent: begin
            if (!router_full[vc_of(cur_q)]) begin
               emit         = 1'b1;
               flit_d       = make_flit(cur_q, TYPE_TAIL, buf_addr[cur_q], buf_data[cur_q]);
               issue[cur_q] = 1'b1;
               state_d      = StIdle;
            end else begin
               stall = 1'b1;
            end
         end
      endcase
   end

   // Responses only count when the steered channel actually has a request in flight.
   always_comb begin
      rx_type  = flit_in[DATA_WIDTH+VC_BITS +: TYPE_BITS];
      rx_msg   = flit_in[DATA_WIDTH-1 -: MSG_BITS];
      rx_extra = flit_in[DATA_WIDTH+VC_BITS+TYPE_BITS +: EXTRA];
      rx_hit   = valid_in && (rx_type == TYPE_BITS'(TYPE_SINGLE)) &&
                 ((rx_msg == MSG_BITS'(MSG_RD_RESP)) || (rx_msg == MSG_BITS'(MSG_WR_ACK)));
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         dec[c] = rx_hit && (rx_extra == EXTRA'(c)) && (out_cnt[c] != '0);
      end
   end

   assign unused_rx = ^{flit_in[FLIT_WIDTH-1 -: 2*ID_BITS], flit_in[DATA_WIDTH +: VC_BITS],
                        grant};

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= StIdle;
         cur_q       <= '0;
         valid_out   <= 1'b0;
         flit_out    <= '0;
         ch_valid    <= '0;
         ch_out_data <= '0;
         err         <= 1'b0;
         stat_sent   <= '0;
         stat_recv   <= '0;
         stat_stall  <= '0;
         buf_valid   <= '0;
         buf_write   <= '0;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            buf_addr[c] <= '0;
            buf_data[c] <= '0;
            out_cnt[c]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         valid_out  <= emit;
         if (emit) flit_out <= flit_d;
         stat_sent  <= stat_sent + STAT_WIDTH'(emit);
         stat_stall <= stat_stall + STAT_WIDTH'(stall);
         stat_recv  <= stat_recv + STAT_WIDTH'(valid_in);
         ch_valid   <= dec;
         if (valid_in && !(|dec)) err <= 1'b1;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (issue[c]) begin
               buf_valid[c] <= 1'b0;
            end else if (capture[c]) begin
               buf_valid[c] <= 1'b1;
               buf_write[c] <= ch_write[c];
               buf_addr[c]  <= ch_address[c*ADDRESS_BITS +: ADDRESS_BITS];
               buf_data[c]  <= ch_in_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
            if (dec[c]) ch_out_data[c*DATA_WIDTH +: DATA_WIDTH] <= flit_in[DATA_WIDTH-1:0];
            unique case ({issue[c], dec[c]})
               2'b10:   if (out_cnt[c] != MAX_OUT) out_cnt[c] <= out_cnt[c] + 1'b1;
               2'b01:   out_cnt[c] <= out_cnt[c] - 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_multichannel_packetizer.sv
// Directed bench: expected flits and responses are queued from the flit layout
// rules and compared on every falling edge; literal checks pin timing and stats.
module tb_mem_multichannel_packetizer;

   localparam int AW = 20;
   localparam int DW = 32;
   localparam int FW = 45;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [3:0]    core_ID = 4'd5;
   logic [1:0]    ch_read = '0, ch_write = '0;
   logic [2*AW-1:0] ch_address = '0;
   logic [2*DW-1:0] ch_in_data = '0;
   logic [1:0]    ch_ready, ch_valid;
   logic [2*DW-1:0] ch_out_data;
   logic [FW-1:0] flit_out;
   logic          valid_out;
   logic [1:0]    router_full = '0;
   logic [FW-1:0] flit_in = '0;
   logic          valid_in = 1'b0;
   logic          err;
   logic [31:0]   stat_sent, stat_recv, stat_stall;

   typedef struct packed {
      logic [1:0]  onehot;
      logic [31:0] data;
   } resp_t;

   logic [FW-1:0] flit_q[$];
   resp_t         resp_q[$];
   logic [FW-1:0] exp_flit;
   resp_t         exp_resp;
   int errors = 0;
   int checks = 0;
   int sent_m = 0;
   int recv_m = 0;

   mem_multichannel_packetizer dut (
      .clock       (clock),
      .reset       (reset),
      .core_ID     (core_ID),
      .ch_read     (ch_read),
      .ch_write    (ch_write),
      .ch_address  (ch_address),
      .ch_in_data  (ch_in_data),
      .ch_ready    (ch_ready),
      .ch_valid    (ch_valid),
      .ch_out_data (ch_out_data),
      .flit_out    (flit_out),
      .valid_out   (valid_out),
      .router_full (router_full),
      .flit_in     (flit_in),
      .valid_in    (valid_in),
      .err         (err),
      .stat_sent   (stat_sent),
      .stat_recv   (stat_recv),
      .stat_stall  (stat_stall)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Flit = {src, dst=addr[19:16], extra=channel, type, vc=channel%2, data}
   function automatic logic [FW-1:0] mk_flit(input int ch, input logic [1:0] typ,
                                            input logic [19:0] addr, input logic [31:0] data);
      logic [1:0] ex;
      logic       vc;
      ex = 2'(ch);
      vc = 1'(ch % 2);
      return {core_ID, addr[19:16], ex, typ, vc, data};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_flit(input int ch, input logic [1:0] typ, input logic [19:0] addr,
                              input logic [31:0] data);
      flit_q.push_back(mk_flit(ch, typ, addr, data));
      sent_m++;
   endtask

   task automatic apply_reset();
      check("queue_drained", 64'(flit_q.size() + resp_q.size()), 64'd0);
      reset = 1'b0;
      ch_read = '0; ch_write = '0; router_full = '0; valid_in = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      flit_q.delete();
      resp_q.delete();
      sent_m = 0;
      recv_m = 0;
   endtask

   task automatic send_resp(input logic [1:0] extra, input logic [2:0] msg,
                            input logic [28:0] payload, input bit ok);
      resp_t r;
      flit_in  = {4'h3, 4'h5, extra, 2'b11, 1'b0, msg, payload};
      valid_in = 1'b1;
      recv_m++;
      if (ok) begin
         r.onehot = 2'b01 << extra;
         r.data   = {msg, payload};
         resp_q.push_back(r);
      end
      tick();
      valid_in = 1'b0;
   endtask

   always @(negedge clock) begin
      if (valid_out) begin
         checks++;
         if (flit_q.size() == 0) begin
            errors++;
            $display("FAIL flit_unexpected: got %h required no flit", flit_out);
         end else begin
            exp_flit = flit_q.pop_front();
            if (flit_out !== exp_flit) begin
               errors++;
               $display("FAIL flit_stream: got %h required %h", flit_out, exp_flit);
            end
         end
      end
      if (ch_valid != 2'b00) begin
         checks++;
         if (resp_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: got ch_valid %b required none", ch_valid);
         end else begin
            exp_resp = resp_q.pop_front();
            if (ch_valid !== exp_resp.onehot ||
                ch_out_data[(ch_valid[1] ? DW : 0) +: DW] !== exp_resp.data) begin
               errors++;
               $display("FAIL resp_stream: got %b/%h required %b/%h", ch_valid,
                        ch_out_data, exp_resp.onehot, exp_resp.data);
            end
         end
      end
   end

   initial begin
      apply_reset();
      check("rst_valid_out", valid_out, 0);
      check("rst_flit_out", flit_out, 0);
      check("rst_err", err, 0);
      check("rst_stats", {stat_sent, stat_recv} | 64'(stat_stall), 0);
      check("rst_ch_valid", ch_valid, 0);
      check("rst_ch_out_data", ch_out_data, 0);
      check("rst_ch_ready", ch_ready, 2'b11);

      // ch0 read: single flit one cycle after capture
      expect_flit(0, 2'b11, 20'h3_0010, {3'b001, 9'b0, 20'h3_0010});
      ch_read = 2'b01;
      ch_address[19:0] = 20'h3_0010;
      tick();
      ch_read = 2'b00;
      check("t1_ready_low", ch_ready[0], 0);
      check("t1_no_flit_yet", valid_out, 0);
      tick();
      check("t1_valid", valid_out, 1);
      check("t1_flit_literal", flit_out, {13'h0a66, 32'h2003_0010});
      check("t1_ready_back", ch_ready[0], 1);
      tick();
      check("t1_single_pulse", valid_out, 0);
      check("t1_stat_sent", stat_sent, 64'(sent_m));

      // ch1 write stalled three cycles on vc1
      apply_reset();
      router_full = 2'b10;
      ch_write = 2'b10;
      ch_address[39:20] = 20'h2_0004;
      ch_in_data[63:32] = 32'hDEAD_BEEF;
      expect_flit(1, 2'b10, 20'h2_0004, {3'b010, 9'b0, 20'h2_0004});
      expect_flit(1, 2'b01, 20'h2_0004, 32'hDEAD_BEEF);
      tick();
      ch_write = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_stalled", valid_out, 0);
      end
      check("t2_stat_stall", stat_stall, 3);
      router_full = 2'b00;
      tick();
      check("t2_head_type", {valid_out, flit_out[34:33]}, 3'b110);
      tick();
      check("t2_tail_type", {valid_out, flit_out[34:33]}, 3'b101);
      check("t2_tail_data", flit_out[31:0], 32'hDEAD_BEEF);
      tick();
      check("t2_after_tail", valid_out, 0);
      check("t2_stat_sent", stat_sent, 64'(sent_m));
      send_resp(2'd1, 3'b101, 29'h55, 1'b1);
      check("t2_wrack_valid", ch_valid, 2'b10);
      check("t2_wrack_data", ch_out_data[63:32], 32'hA000_0055);
      tick();
      check("t2_wrack_pulse", ch_valid, 2'b00);
      check("t2_wrack_hold", ch_out_data[63:32], 32'hA000_0055);
      check("t2_no_err", err, 0);

      // simultaneous reads: ch0 first both rounds
      apply_reset();
      for (int r = 0; r < 2; r++) begin
         ch_read = 2'b11;
         ch_address = {20'h4_0008 + 20'(r), 20'h1_0000 + 20'(r)};
         expect_flit(0, 2'b11, 20'h1_0000 + 20'(r), {3'b001, 9'b0, 20'h1_0000 + 20'(r)});
         expect_flit(1, 2'b11, 20'h4_0008 + 20'(r), {3'b001, 9'b0, 20'h4_0008 + 20'(r)});
         tick();
         ch_read = 2'b00;
         tick();
         check("t3_first_ch0", {valid_out, flit_out[36:35]}, 3'b100);
         tick();
         check("t3_second_ch1", {valid_out, flit_out[36:35]}, 3'b101);
      end
      tick();
      check("t3_idle", valid_out, 0);

      // outstanding limit of three on ch0
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         check("t4_ready_before", ch_ready[0], 1);
         expect_flit(0, 2'b11, 20'h1_0000 + 20'(k), {3'b001, 9'b0, 20'h1_0000 + 20'(k)});
         ch_read = 2'b01;
         ch_address[19:0] = 20'h1_0000 + 20'(k);
         tick();
         ch_read = 2'b00;
         tick();
      end
      check("t4_ready_full", ch_ready[0], 0);
      tick();
      check("t4_ready_still_full", ch_ready[0], 0);
      send_resp(2'd0, 3'b100, 29'h1234, 1'b1);
      check("t4_resp_valid", ch_valid, 2'b01);
      check("t4_resp_data", ch_out_data[31:0], 32'h8000_1234);
      check("t4_ready_freed", ch_ready[0], 1);
      tick();
      check("t4_resp_pulse", ch_valid, 2'b00);
      check("t4_stat_recv", stat_recv, 64'(recv_m));

      // misrouted and unexpected responses
      apply_reset();
      send_resp(2'd3, 3'b100, 29'h77, 1'b0);
      check("t5_no_valid", ch_valid, 2'b00);
      check("t5_err", err, 1);
      check("t5_stat_recv", stat_recv, 1);
      tick();
      check("t5_err_sticky", err, 1);
      send_resp(2'd0, 3'b100, 29'h78, 1'b0);
      check("t5_no_outstanding", ch_valid, 2'b00);
      check("t5_stat_recv2", stat_recv, 64'(recv_m));

      // reset right after a head: tail must never appear
      apply_reset();
      expect_flit(1, 2'b10, 20'h2_0004, {3'b010, 9'b0, 20'h2_0004});
      ch_write = 2'b10;
      ch_address[39:20] = 20'h2_0004;
      tick();
      ch_write = 2'b00;
      tick();
      check("t6_head", {valid_out, flit_out[34:33]}, 3'b110);
      reset = 1'b0;
      tick();
      check("t6_valid_cleared", valid_out, 0);
      check("t6_stats_cleared", {stat_sent, stat_stall} | 64'(stat_recv), 0);
      check("t6_err_cleared", err, 0);
      reset = 1'b1;
      check("t6_ready", ch_ready, 2'b11);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t6_no_tail", valid_out, 0);
      end
      expect_flit(0, 2'b11, 20'h1_0000, {3'b001, 9'b0, 20'h1_0000});
      ch_read = 2'b01;
      ch_address[19:0] = 20'h1_0000;
      tick();
      ch_read = 2'b00;
      tick();
      check("t6_idle_single", {valid_out, flit_out[34:33]}, 3'b111);
      tick();

      check("final_queues_empty", 64'(flit_q.size() + resp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_multichannel_packetizer.md
Name: mem_multichannel_packetizer

Overview:
- Parametrised successor to the fixed two-port (instruction/data) memory packetizer.
- Serves CHANNELS independent core-side memory request ports. Each port gets a one-entry request buffer, a per-channel outstanding-request limit and a per-channel VC binding.
- A round-robin arbiter selects a channel; a TX FSM emits single-flit reads or head+tail writes into the router local input port, honouring per-VC full.
- Returning response flits are steered to their channel by the EXTRA field of the flow ID.

Parameters:
- CHANNELS, 2, number of core-side request ports; must be <= 2**EXTRA.
- ID_BITS, 4, node ID width.
- DATA_WIDTH, 32, flit payload width; must be >= MSG_BITS+ADDRESS_BITS.
- ADDRESS_BITS, 20, request address width; the top ID_BITS bits give the destination node.
- VC_BITS, 1, log2 of VCs per port.
- EXTRA, 2, extra flow bits; they carry the channel index.
- TYPE_BITS, 2, flit type width.
- MSG_BITS, 3, message opcode width.
- OUT_BITS, 2, outstanding counter width; MAX_OUTSTANDING = 2**OUT_BITS - 1.
- STAT_WIDTH, 32, statistics counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- core_ID  in  ID_BITS  source ID placed in flow.
- ch_read  in  CHANNELS  per-channel read request.
- ch_write  in  CHANNELS  per-channel write request.
- ch_address  in  CHANNELS*ADDRESS_BITS  request addresses, channel c at slice c.
- ch_in_data  in  CHANNELS*DATA_WIDTH  write data.
- ch_ready  out  CHANNELS  channel may present a request this cycle.
- ch_valid  out  CHANNELS  one-cycle response pulse.
- ch_out_data  out  CHANNELS*DATA_WIDTH  response data, held until next response on that channel.
- flit_out  out  FLIT_WIDTH  flit to router; FLIT_WIDTH = FLOW_BITS+TYPE_BITS+VC_BITS+DATA_WIDTH.
- valid_out  out  1  flit_out valid.
- router_full  in  2**VC_BITS  router local input VC full flags.
- flit_in  in  FLIT_WIDTH  response flit from router.
- valid_in  in  1  flit_in valid; always accepted.
- err  out  1  sticky: misrouted/unexpected response.
- stat_sent, stat_recv, stat_stall  out  STAT_WIDTH each  flits sent, flits received, cycles blocked by router_full.

Behaviour:
- Reset (reset==0 at posedge) clears the following, with no partial packet completed:
  - outputs: valid_out, flit_out, ch_valid, ch_out_data, err, all stats;
  - state: buffers, counters, RR pointer (channel 0 highest priority), FSM (IDLE).
- Flit layout, MSB first: {flow, type, vc, data}.
  - flow = {src=core_ID, dst=addr[ADDRESS_BITS-1 -: ID_BITS], extra=channel}.
  - Types: SINGLE=2'b11, HEAD=2'b10, BODY=2'b00, TAIL=2'b01.
  - Msgs: READ=3'b001, WRITE=3'b010, RD_RESP=3'b100, WR_ACK=3'b101.
  - Head/single data = {msg, zero pad, address}; tail data = write data.
- VC binding: channel c uses vc = c mod 2**VC_BITS.
- ch_ready[c] = buffer empty AND outstanding[c] < MAX_OUTSTANDING.
- Capture: read|write while ready → buffer captured at that edge. Read and write both high → write wins.
- TX FSM:
  - IDLE: pick the next full buffer in RR order whose VC is not full. If none is eligible and some buffer is full, increment stat_stall.
    - Read: drive SINGLE, free buffer, outstanding++, stay IDLE.
    - Write: drive HEAD, go HEAD_SENT.
  - HEAD_SENT: emit TAIL when router_full[vc]==0, else hold (stall++). On emit: free buffer, outstanding++, go IDLE.
  - The RR pointer advances to (granted+1) mod CHANNELS on each grant.
- Latency: request captured at edge t → flit valid_out in cycle t+1 at earliest. Write tail at t+2 at earliest.
- valid_out is registered; it is high exactly one cycle per flit.
- RX: valid_in with type SINGLE, msg RD_RESP/WR_ACK, extra<CHANNELS and outstanding[extra]>0 → next cycle ch_valid[extra]=1, ch_out_data=data (WR_ACK data as received), outstanding--.
  - Otherwise drop and set err; stat_recv still counts.
- Same-cycle issue and response on one channel → outstanding unchanged.
- Counters saturate at MAX_OUTSTANDING and never underflow. Stats wrap modulo 2**STAT_WIDTH.

Decomposition:
- Shared package holds: flit type/msg constants, FLOW_BITS/FLIT_WIDTH localparam expressions, log2 function.
- One sub-module: rr_arbiter (CHANNELS-wide request/grant with registered pointer), reusable by router allocators.

Test Plan:
- core_ID=5, ch0 read addr 20'h3_0010 → next cycle valid_out=1, flow={5,3,0}, type=11, vc=0, data={001, 0…, 20'h30010}; ch_ready[0] low for one cycle only.
- ch1 write addr 20'h2_0004 data 32'hDEADBEEF, router_full[1]=1 for 3 cycles → no valid_out, stat_stall=3; then HEAD and TAIL (data DEADBEEF) in consecutive cycles.
- ch0 and ch1 read in the same cycle from reset → ch0 flit first, ch1 next cycle. Repeat → ch0 first again (pointer back to 0 after ch1 grant).
- OUT_BITS=2: three ch0 reads → ch_ready[0]=0. RD_RESP extra=0 data 32'h1234 → ch_valid[0] one cycle later with 1234, ch_ready[0]=1.
- CHANNELS=2, response with extra=3 → no ch_valid, err=1 sticky, stat_recv=1.
- Drive reset=0 the cycle after a HEAD → next edge valid_out=0, FSM IDLE, all stats 0, no TAIL ever sent.
